core_ifq: RTL and testbench

- Instruction queue between the fetch stage and the decode stage of the i2d core.
- Buffers fetched instruction/PC pairs so that decode stalls do not immediately stall the bus.
- Drives the fetch halt request and flushes all buffered words on a PC redirect (branch or exception).
- Presents a NOP to decode whenever it holds no valid word.

---
 rtl/core_ifq_if.sv | 28 ++
 rtl/core_ifq.sv | 128 ++++++++++++
 tb/tb_core_ifq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_ifq_if.sv
// Fetch/decode handshake bundle for the core_ifq instruction queue.
// The queue itself connects through the slave modport.
interface core_ifq_if #(
    parameter int AW = 2
);
    logic          fetch_valid;
    logic [31:0]   fetch_ins;
    logic [31:0]   fetch_pc;
    logic          fetch_err;
    logic          fetch_halt;
    logic          flush;
    logic          id_ready;
    logic          id_valid;
    logic [31:0]   id_ins;
    logic [31:0]   id_pc;
    logic          id_err;
    logic [AW:0]   ifq_count;

    modport master (
        output fetch_valid, fetch_ins, fetch_pc, fetch_err, flush, id_ready,
        input  fetch_halt, id_valid, id_ins, id_pc, id_err, ifq_count
    );

    modport slave (
        input  fetch_valid, fetch_ins, fetch_pc, fetch_err, flush, id_ready,
        output fetch_halt, id_valid, id_ins, id_pc, id_err, ifq_count
    );
endinterface

// File: rtl/core_ifq.sv
// Fetch-to-decode instruction queue: circular buffer with flush, error lock and NOP fill.
// Optional same-cycle empty-queue bypass is enabled by defining CORE_IFQ_BYPASS_EN.
module core_ifq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic      clk,
    input  logic      rst,
    core_ifq_if.slave ifq
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   ins_mem_r [DEPTH];
    logic [31:0]   pc_mem_r  [DEPTH];
    logic          err_mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_nx_s;
    logic [AW-1:0] wr_ptr_nx_s;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nx_s;
    logic          err_lock_r;
    logic          err_lock_nx_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          byp_s;
    logic          take_err_s;

    // Queue control terms and the fetch halt request
    always_comb begin
        full_s  = (count_r == FULL_CNT);
        empty_s = (count_r == {(AW+1){1'b0}});
`ifdef CORE_IFQ_BYPASS_EN
        byp_s   = empty_s & ifq.fetch_valid & ~ifq.flush & ~err_lock_r;
`else
        byp_s   = 1'b0;
`endif
        // A bypassed word that decode takes immediately never occupies a slot
        push_s  = ifq.fetch_valid & ~full_s & ~err_lock_r & ~ifq.flush
                  & ~(byp_s & ifq.id_ready);
        pop_s   = ifq.id_ready & ~empty_s & ~ifq.flush;
        take_err_s = ifq.fetch_err & (push_s | (byp_s & ifq.id_ready));
        ifq.fetch_halt = full_s | err_lock_r | ifq.flush;
    end

    // Next pointer, occupancy and error-lock values
    always_comb begin
        rd_ptr_nx_s   = rd_ptr_r;
        wr_ptr_nx_s   = wr_ptr_r;
        count_nx_s    = count_r;
        err_lock_nx_s = err_lock_r;
        if (ifq.flush) begin
            rd_ptr_nx_s   = {AW{1'b0}};
            wr_ptr_nx_s   = {AW{1'b0}};
            count_nx_s    = {(AW+1){1'b0}};
            err_lock_nx_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_nx_s = wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_nx_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nx_s = rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nx_s = count_r + (AW+1)'(1);
                2'b01:   count_nx_s = count_r - (AW+1)'(1);
                default: count_nx_s = count_r;
            endcase
            if (take_err_s) begin
                err_lock_nx_s = 1'b1;
            end else begin
                err_lock_nx_s = err_lock_r;
            end
        end
    end

    // Pointer, occupancy and error-lock registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            err_lock_r <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_nx_s;
            wr_ptr_r   <= wr_ptr_nx_s;
            count_r    <= count_nx_s;
            err_lock_r <= err_lock_nx_s;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            ins_mem_r[wr_ptr_r] <= ifq.fetch_ins;
            pc_mem_r[wr_ptr_r]  <= ifq.fetch_pc;
            err_mem_r[wr_ptr_r] <= ifq.fetch_err;
        end
    end

    // Decode-side view: bypass word, head entry, or NOP filler
    always_comb begin
        ifq.ifq_count = count_r;
        if (byp_s) begin
            ifq.id_valid = 1'b1;
            ifq.id_ins   = ifq.fetch_ins;
            ifq.id_pc    = ifq.fetch_pc;
            ifq.id_err   = ifq.fetch_err;
        end else if (!empty_s) begin
            ifq.id_valid = 1'b1;
            ifq.id_ins   = ins_mem_r[rd_ptr_r];
            ifq.id_pc    = pc_mem_r[rd_ptr_r];
            ifq.id_err   = err_mem_r[rd_ptr_r];
        end else begin
            ifq.id_valid = 1'b0;
            ifq.id_ins   = NOP;
            ifq.id_pc    = 32'h0000_0000;
            ifq.id_err   = 1'b0;
        end
    end
endmodule

// File: tb/tb_core_ifq.sv
// Self-checking bench for core_ifq (default build, no bypass) against a queue-based model.
module tb_core_ifq;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [64:0] mq[$];
    bit          m_lock = 1'b0;
    logic [69:0] exp_v;

    always #5 clk = ~clk;

    core_ifq_if #(.AW(2)) bus ();
    core_ifq #(.DEPTH(4), .AW(2)) dut (.clk(clk), .rst(rst), .ifq(bus));

    function automatic logic [69:0] obs_v();
        return {bus.id_valid, bus.id_ins, bus.id_pc, bus.id_err, bus.fetch_halt, bus.ifq_count};
    endfunction

    // Apply inputs for this cycle, let outputs settle, and form the model's expectation
    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit err, input bit fl, input bit rdy, input bit r);
        int n;
        bus.fetch_valid = v;  bus.fetch_ins = ins;  bus.fetch_pc = pc;
        bus.fetch_err = err;  bus.flush = fl;       bus.id_ready = rdy;
        rst = r;
        #1;
        n = mq.size();
        exp_v = {n > 0, (n > 0) ? mq[0][31:0] : NOP, (n > 0) ? mq[0][63:32] : 32'h0,
                 (n > 0) ? mq[0][64] : 1'b0, (n == 4) || m_lock || fl, 3'(n)};
    endtask

    // Advance one clock edge, updating the model from the applied inputs
    task automatic step();
        bit do_push;
        bit do_pop;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_lock = 1'b0;
        end else if (bus.flush) begin
            mq.delete();
            m_lock = 1'b0;
        end else begin
            do_push = bus.fetch_valid && (mq.size() < 4) && !m_lock;
            do_pop  = bus.id_ready && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({bus.fetch_err, bus.fetch_pc, bus.fetch_ins});
                if (bus.fetch_err) m_lock = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_v() !== exp_v) begin
            failures++;
            $display("FAIL reset_model got=%h want=%h", obs_v(), exp_v);
        end
        checks++;
        if ({bus.id_valid, bus.id_ins, bus.id_pc, bus.fetch_halt, bus.ifq_count} !== {1'b0, NOP, 32'h0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_idle valid=%b ins=%h pc=%h halt=%b cnt=%0d", bus.id_valid, bus.id_ins, bus.id_pc, bus.fetch_halt, bus.ifq_count);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h1111_1111 * (i + 1), 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_v() !== exp_v) begin
                failures++;
                $display("FAIL fill_%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.ifq_count, bus.fetch_halt} !== {3'd4, 1'b1}) begin
            failures++;
            $display("FAIL fill_full cnt=%0d halt=%b want 4/1", bus.ifq_count, bus.fetch_halt);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({bus.id_valid, bus.id_pc, bus.id_ins} !== {1'b1, 32'(4 * i), 32'h1111_1111 * (i + 1)}) begin
                failures++;
                $display("FAIL drain_%0d pc=%h ins=%h want pc=%h", i, bus.id_pc, bus.id_ins, 32'(4 * i));
            end
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_v() !== exp_v || bus.id_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got=%h want=%h", obs_v(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, $urandom, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs_v() !== exp_v) begin
                failures++;
                $display("FAIL stream_%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            if (i > 0) begin
                checks++;
                if ({bus.ifq_count, bus.id_pc} !== {3'd1, 32'h100 + 32'(4 * (i - 1))}) begin
                    failures++;
                    $display("FAIL stream_pc_%0d cnt=%0d pc=%h want 1/%h", i, bus.ifq_count, bus.id_pc, 32'h100 + 32'(4 * (i - 1)));
                end
            end
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'hDEAD_BEEF, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_v() !== exp_v) begin
            failures++;
            $display("FAIL flush_cycle got=%h want=%h", obs_v(), exp_v);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({bus.ifq_count, bus.id_valid, bus.fetch_halt} !== 5'b000_0_0 || bus.id_pc === 32'h200) begin
                failures++;
                $display("FAIL flush_after_%0d cnt=%0d valid=%b pc=%h", i, bus.ifq_count, bus.id_valid, bus.id_pc);
            end
            step();
        end
    endtask

    task automatic test_err_lock();
        drive(1'b1, 32'hCAFE_0001, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 32'h44 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({bus.fetch_halt, bus.id_err, bus.id_pc, bus.ifq_count} !== {1'b1, 1'b1, 32'h40, 3'd1}) begin
                failures++;
                $display("FAIL err_hold_%0d halt=%b err=%b pc=%h cnt=%0d", i, bus.fetch_halt, bus.id_err, bus.id_pc, bus.ifq_count);
            end
            step();
        end
        drive(1'b1, 32'h0, 32'h50, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h0, 32'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.fetch_halt, bus.ifq_count, bus.id_valid} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL err_drained halt=%b cnt=%0d valid=%b", bus.fetch_halt, bus.ifq_count, bus.id_valid);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.fetch_halt !== 1'b0 || obs_v() !== exp_v) begin
            failures++;
            $display("FAIL err_unlock halt=%b got=%h want=%h", bus.fetch_halt, obs_v(), exp_v);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h1234_5678, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.ifq_count, bus.id_valid} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid cnt=%0d valid=%b want 0/0", bus.ifq_count, bus.id_valid);
        end
        drive(1'b1, 32'hABCD_0080, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.id_valid, bus.id_pc, bus.id_ins, bus.ifq_count} !== {1'b1, 32'h80, 32'hABCD_0080, 3'd1}) begin
            failures++;
            $display("FAIL rst_first_push pc=%h ins=%h cnt=%0d want pc=00000080", bus.id_pc, bus.id_ins, bus.ifq_count);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom, ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (obs_v() !== exp_v) begin
                failures++;
                $display("FAIL random_%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            step();
        end
    endtask

    initial begin
        bus.fetch_valid = 1'b0; bus.fetch_ins = 32'h0; bus.fetch_pc = 32'h0;
        bus.fetch_err = 1'b0;   bus.flush = 1'b0;      bus.id_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_err_lock();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
